// File: rtl/rx_sample_assembler_pkg.sv
// Shared definitions for the RX byte-pair to FIR sample assembler.
// Holds the FSM encoding, default widths and the drop counter ceiling.
package rx_sample_assembler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_MSB = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    localparam int BYTE_W_DEF   = 8;
    localparam int SAMPLE_W_DEF = 16;

    localparam logic [7:0] DROP_SAT = 8'd255;

endpackage

// File: rtl/rx_sample_assembler_gap.sv
// Inter-byte gap counter: measures cycles spent waiting for the MSB.
// expire is asserted while enabled on the last allowed waiting cycle.
module rx_gap_timer #(
    parameter int TO_W        = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/rx_sample_assembler.sv
// Packs UART bytes (LSB first) into 16-bit FIR samples with a start strobe,
// an MSB timeout guard and overrun accounting for bytes arriving while blocked.
module rx_sample_assembler
    import rx_sample_assembler_pkg::*;
#(
    parameter int BYTE_W      = BYTE_W_DEF,
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int TO_W        = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RxD_data_ready,
    input  logic [BYTE_W-1:0]   RxD_data,
    input  logic                FIR_busy,
    input  logic                ovr_clr,
    output logic [SAMPLE_W-1:0] FIR_sample,
    output logic                FIR_start,
    output logic                timeout_err,
    output logic                overrun,
    output logic [7:0]          drop_cnt
);

    state_t            state;
    logic [BYTE_W-1:0] lsb;
    logic              gap_clear;
    logic              gap_enable;
    logic              gap_expire;
    logic              drop;

    assign gap_clear  = (state == IDLE) && RxD_data_ready;
    assign gap_enable = (state == GET_MSB) && !RxD_data_ready;
    // Every byte seen in ISSUE is lost, including the one on the leaving cycle.
    assign drop       = (state == ISSUE) && RxD_data_ready;

    rx_gap_timer #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap (
        .clk    (clk),
        .rst    (rst),
        .clear  (gap_clear),
        .enable (gap_enable),
        .expire (gap_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            lsb         <= '0;
            FIR_sample  <= '0;
            FIR_start   <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            FIR_start   <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (RxD_data_ready) begin
                        lsb   <= RxD_data;
                        state <= GET_MSB;
                    end
                end
                GET_MSB: begin
                    // A byte on the final waiting cycle beats the timeout.
                    if (RxD_data_ready) begin
                        FIR_sample <= {RxD_data, lsb};
                        state      <= ISSUE;
                    end else if (gap_expire) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                ISSUE: begin
                    if (!FIR_busy) begin
                        FIR_start <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (drop) begin
                overrun  <= 1'b1;
                if (ovr_clr) begin
                    drop_cnt <= 8'd1;
                end else if (drop_cnt != DROP_SAT) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (ovr_clr) begin
                overrun  <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rx_sample_assembler.sv
// Bench for rx_sample_assembler: directed scenarios plus random traffic,
// checked every cycle against a time-stamp based behavioural model.
module tb_rx_sample_assembler;
    import rx_sample_assembler_pkg::*;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        busy = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] fir_sample;
    logic        fir_start;
    logic        timeout_err;
    logic        overrun;
    logic [7:0]  drop_cnt;

    int tests = 0;
    int errors = 0;
    int start_cnt = 0;
    int to_cnt = 0;

    rx_sample_assembler #(
        .BYTE_W      (8),
        .SAMPLE_W    (16),
        .TO_W        (16),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RxD_data_ready (rdy),
        .RxD_data       (data),
        .FIR_busy       (busy),
        .ovr_clr        (clr),
        .FIR_sample     (fir_sample),
        .FIR_start      (fir_start),
        .timeout_err    (timeout_err),
        .overrun        (overrun),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: a waiting LSB carries its capture time; a finished
    // sample waits in a pending slot until the FIR is free.
    bit          have_lsb = 0;
    bit          pending = 0;
    logic [7:0]  m_lsb = 0;
    int          lsb_cyc = 0;
    int          cyc = 0;
    logic [15:0] m_sample = 0;
    bit          m_start = 0;
    bit          m_to = 0;
    bit          m_ovr = 0;
    int          m_cnt = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk) begin
        bit dropped;
        dropped = 0;
        m_start = 0;
        m_to = 0;
        if (!rst) begin
            have_lsb = 0;
            pending = 0;
            m_lsb = 0;
            m_sample = 0;
            m_ovr = 0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (pending) begin
                dropped = rdy;
                if (!busy) begin
                    m_start = 1;
                    pending = 0;
                    exp_q.push_back(m_sample);
                end
            end else if (have_lsb) begin
                if (rdy) begin
                    m_sample = {data, m_lsb};
                    pending = 1;
                    have_lsb = 0;
                end else if (cyc - lsb_cyc == T) begin
                    m_to = 1;
                    have_lsb = 0;
                end
            end else if (rdy) begin
                m_lsb = data;
                have_lsb = 1;
                lsb_cyc = cyc;
            end
            if (dropped) begin
                m_ovr = 1;
                m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (clr) begin
                m_ovr = 0;
                m_cnt = 0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        tests++;
        if (fir_sample !== m_sample || fir_start !== m_start || timeout_err !== m_to ||
            overrun !== m_ovr || drop_cnt !== 8'(m_cnt)) begin
            errors++;
            $display("FAIL cycle_check t=%0t: got sample=%h start=%b to=%b ovr=%b cnt=%0d, want sample=%h start=%b to=%b ovr=%b cnt=%0d",
                     $time, fir_sample, fir_start, timeout_err, overrun, drop_cnt,
                     m_sample, m_start, m_to, m_ovr, m_cnt);
        end
        if (fir_start === 1'b1) begin
            start_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL start_scoreboard: got start with sample=%h, want no start", fir_sample);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (fir_sample !== e) begin
                    errors++;
                    $display("FAIL start_scoreboard: got sample=%h, want %h", fir_sample, e);
                end
            end
        end
        if (timeout_err === 1'b1) to_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rdy = 1'b1;
        data = b;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    initial begin
        int s0;
        int t0;

        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            rdy = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            busy = 1'($urandom_range(0, 1));
            clr = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("reset_outputs", {fir_sample, fir_start, timeout_err, overrun, drop_cnt}, 32'h0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b1; rdy = 1'b0; busy = 1'b0; clr = 1'b0;
        idle(2);
        check("idle_after_release", 32'(dut.state), 32'(IDLE));

        // 2: basic pair and latency
        send_byte(8'h34);
        send_byte(8'h12);
        check("pair_sample", 32'(fir_sample), 32'h1234);
        check("pair_start_n1", 32'(fir_start), 32'h0);
        idle(1);
        check("pair_start_n2", 32'(fir_start), 32'h1);
        idle(1);
        check("pair_start_n3", 32'(fir_start), 32'h0);

        // 3: blocked FIR with one overrun byte
        busy = 1'b1;
        send_byte(8'hCD);
        send_byte(8'hAB);
        #1 s0 = start_cnt;
        idle(2);
        send_byte(8'h55);
        idle(5);
        #1 check("busy_no_start", 32'(start_cnt - s0), 32'h0);
        busy = 1'b0;
        idle(3);
        #1 check("busy_one_start", 32'(start_cnt - s0), 32'h1);
        check("busy_overrun", 32'(overrun), 32'h1);
        check("busy_drop_cnt", 32'(drop_cnt), 32'h1);
        check("busy_sample", 32'(fir_sample), 32'hABCD);

        // 4: lost MSB
        #1 t0 = to_cnt;
        send_byte(8'h77);
        idle(T + 4);
        #1 check("timeout_once", 32'(to_cnt - t0), 32'h1);
        send_byte(8'h01);
        send_byte(8'h02);
        idle(2);
        check("after_timeout_sample", 32'(fir_sample), 32'h0201);

        // 5: MSB on the final waiting cycle, then one cycle too late
        #1 t0 = to_cnt; s0 = start_cnt;
        send_byte(8'h5A);
        idle(T - 1);
        send_byte(8'hA5);
        idle(3);
        #1 check("edge_no_timeout", 32'(to_cnt - t0), 32'h0);
        check("edge_start", 32'(start_cnt - s0), 32'h1);
        check("edge_sample", 32'(fir_sample), 32'hA55A);
        #1 t0 = to_cnt;
        send_byte(8'h5A);
        idle(T);
        send_byte(8'hA5);
        send_byte(8'h3C);
        idle(3);
        #1 check("late_timeout", 32'(to_cnt - t0), 32'h1);
        check("late_sample", 32'(fir_sample), 32'h3CA5);

        // 6: reset in GET_MSB discards the stale LSB
        send_byte(8'h99);
        idle(3);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        #1 s0 = start_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        idle(3);
        #1 check("rst_mid_start", 32'(start_cnt - s0), 32'h1);
        check("rst_mid_sample", 32'(fir_sample), 32'h2211);

        // Saturation and clear
        busy = 1'b1;
        send_byte(8'hA0);
        send_byte(8'hA1);
        rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            data = 8'(i);
            @(negedge clk);
        end
        rdy = 1'b0;
        check("sat_cnt", 32'(drop_cnt), 32'd255);
        check("sat_ovr", 32'(overrun), 32'h1);
        clr = 1'b1;
        idle(1);
        check("clr_cnt", 32'(drop_cnt), 32'h0);
        check("clr_ovr", 32'(overrun), 32'h0);
        rdy = 1'b1;
        idle(1);
        rdy = 1'b0; clr = 1'b0;
        check("clr_drop_cnt", 32'(drop_cnt), 32'h1);
        check("clr_drop_ovr", 32'(overrun), 32'h1);
        busy = 1'b0;
        idle(3);
        check("sat_sample", 32'(fir_sample), 32'hA1A0);

        // Random traffic in blocks of varying byte density
        for (int blk = 0; blk < 24; blk++) begin
            int p;
            int pb;
            p = (blk % 3 == 0) ? 40 : $urandom_range(1, 4);
            pb = $urandom_range(0, 3);
            for (int i = 0; i < 100; i++) begin
                rdy = ($urandom_range(0, p - 1) == 0);
                data = 8'($urandom);
                busy = ($urandom_range(0, 3) < pb);
                clr = ($urandom_range(0, 40) == 0);
                rst = ($urandom_range(0, 300) != 0);
                @(negedge clk);
            end
        end
        rst = 1'b1; rdy = 1'b0; busy = 1'b0; clr = 1'b0;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
